// File: rtl/icg_ctrl_pkg.sv
// Shared types and constants for the icgtn enable controller.
package icg_ctrl_pkg;

  typedef enum logic [1:0] {
    StWake  = 2'd0,
    StRun   = 2'd1,
    StIdle  = 2'd2,
    StGated = 2'd3
  } icg_state_t;

  localparam int unsigned WCNT_W = 4;

endpackage

// File: rtl/icg_idle_counter.sv
// Saturating idle-cycle counter with a terminal-count compare against a live limit.
module icg_idle_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             reached_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   cnt_p1;

  // Extra bit keeps cnt+1 from wrapping when the count is saturated.
  assign cnt_p1    = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
  assign reached_o = (cnt_p1 >= {1'b0, limit_i}) && (limit_i != '0);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_p1[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/icg_enable_ctrl.sv
// Idle-timeout enable controller driving the E/TE pins of a negative-edge clock gate.
module icg_enable_ctrl
  import icg_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned WAKE_LAT = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             BUSY,
  input  logic             REQ,
  input  logic             FORCE_ON,
  input  logic             SE,
  input  logic [CNT_W-1:0] IDLE_LIMIT,
  output logic             E,
  output logic             TE,
  output logic             READY,
  output logic             GATED
);

  localparam logic [WCNT_W-1:0] WakeLatCnt = WCNT_W'(WAKE_LAT);
  localparam icg_state_t        ResetState = (WAKE_LAT == 0) ? StRun : StWake;
  localparam logic              ResetReady = (WAKE_LAT == 0);

  icg_state_t        state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              e_q, e_d;
  logic              ready_q, ready_d;
  logic              gated_q, gated_d;
  logic              idle;
  logic              cnt_inc;
  logic              cnt_clr;
  logic              reached;

  assign idle    = !BUSY && !REQ && !FORCE_ON;
  assign cnt_clr = !cnt_inc;

  icg_idle_counter #(
    .CNT_W (CNT_W)
  ) u_idle_counter (
    .clk_i     (CLK),
    .rst_i     (RST),
    .clr_i     (cnt_clr),
    .inc_i     (cnt_inc),
    .limit_i   (IDLE_LIMIT),
    .reached_o (reached)
  );

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    cnt_inc = 1'b0;
    unique case (state_q)
      StWake: begin
        wcnt_d = wcnt_q - WCNT_W'(1);
        if (wcnt_q <= WCNT_W'(1)) begin
          state_d = StRun;
        end
      end
      StRun, StIdle: begin
        if (idle && (IDLE_LIMIT != '0)) begin
          if (reached) begin
            state_d = StGated;
          end else begin
            state_d = StIdle;
            cnt_inc = 1'b1;
          end
        end else begin
          state_d = StRun;
        end
      end
      StGated: begin
        if (!idle) begin
          if (WAKE_LAT == 0) begin
            state_d = StRun;
          end else begin
            state_d = StWake;
            wcnt_d  = WakeLatCnt;
          end
        end
      end
      default: state_d = ResetState;
    endcase
  end

  // Outputs are a registered decode of the next state so they change only after a rising edge.
  always_comb begin
    e_d     = (state_d != StGated);
    ready_d = (state_d == StRun) || (state_d == StIdle);
    gated_d = (state_d == StGated);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ResetState;
      wcnt_q  <= WakeLatCnt;
      e_q     <= 1'b1;
      ready_q <= ResetReady;
      gated_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      e_q     <= e_d;
      ready_q <= ready_d;
      gated_q <= gated_d;
    end
  end

  assign E     = e_q;
  assign TE    = SE | FORCE_ON;
  assign READY = ready_q;
  assign GATED = gated_q;

endmodule

// File: tb/tb_icg_enable_ctrl.sv
// Directed bench for icg_enable_ctrl with WAKE_LAT=2 and WAKE_LAT=0 instances on shared inputs.
module tb_icg_enable_ctrl;

  logic       clk;
  logic       rst;
  logic       busy;
  logic       req;
  logic       force_on;
  logic       se;
  logic [7:0] limit;
  logic       e, te, ready, gated;
  logic       e0, te0, ready0, gated0;

  int total = 0;
  int bad   = 0;

  icg_enable_ctrl #(
    .CNT_W    (8),
    .WAKE_LAT (2)
  ) u_dut (
    .CLK        (clk),
    .RST        (rst),
    .BUSY       (busy),
    .REQ        (req),
    .FORCE_ON   (force_on),
    .SE         (se),
    .IDLE_LIMIT (limit),
    .E          (e),
    .TE         (te),
    .READY      (ready),
    .GATED      (gated)
  );

  icg_enable_ctrl #(
    .CNT_W    (8),
    .WAKE_LAT (0)
  ) u_dut0 (
    .CLK        (clk),
    .RST        (rst),
    .BUSY       (busy),
    .REQ        (req),
    .FORCE_ON   (force_on),
    .SE         (se),
    .IDLE_LIMIT (limit),
    .E          (e0),
    .TE         (te0),
    .READY      (ready0),
    .GATED      (gated0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    busy = 1'b1;
    step(3);
    total++;
    if ({e, ready, gated} !== 3'b100) begin
      bad++;
      $display("FAIL reset_hold: got E/READY/GATED=%b want 100", {e, ready, gated});
    end
    total++;
    if ({e0, ready0, gated0} !== 3'b110) begin
      bad++;
      $display("FAIL reset_hold_lat0: got E/READY/GATED=%b want 110", {e0, ready0, gated0});
    end
    rst = 1'b0;
    step(1);
    total++;
    if ({e, ready, gated} !== 3'b100) begin
      bad++;
      $display("FAIL reset_edge1: got E/READY/GATED=%b want 100", {e, ready, gated});
    end
    step(1);
    total++;
    if ({e, ready, gated} !== 3'b110) begin
      bad++;
      $display("FAIL reset_edge2: got E/READY/GATED=%b want 110", {e, ready, gated});
    end
  endtask

  task automatic test_idle_timeout();
    limit = 8'd4;
    busy  = 1'b0;
    step(2);
    busy = 1'b1;
    step(1);
    busy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      total++;
      if ({e, gated} !== 2'b10) begin
        bad++;
        $display("FAIL timeout_restart_%0d: got E/GATED=%b want 10", i, {e, gated});
      end
    end
    step(1);
    total++;
    if ({e, ready, gated} !== 3'b001) begin
      bad++;
      $display("FAIL timeout_gate: got E/READY/GATED=%b want 001", {e, ready, gated});
    end
  endtask

  task automatic test_wake();
    req = 1'b1;
    step(1);
    total++;
    if ({e, ready, gated} !== 3'b100) begin
      bad++;
      $display("FAIL wake_edge0: got E/READY/GATED=%b want 100", {e, ready, gated});
    end
    total++;
    if ({e0, ready0, gated0} !== 3'b110) begin
      bad++;
      $display("FAIL wake_zero_lat: got E/READY/GATED=%b want 110", {e0, ready0, gated0});
    end
    step(1);
    total++;
    if (ready !== 1'b0) begin
      bad++;
      $display("FAIL wake_edge1: got READY=%b want 0", ready);
    end
    step(1);
    total++;
    if (ready !== 1'b1) begin
      bad++;
      $display("FAIL wake_edge2: got READY=%b want 1", ready);
    end
    req = 1'b0;
    step(3);
    total++;
    if (gated !== 1'b0) begin
      bad++;
      $display("FAIL wake_regate_early: got GATED=%b want 0", gated);
    end
    step(1);
    total++;
    if ({e, gated} !== 2'b01) begin
      bad++;
      $display("FAIL wake_regate: got E/GATED=%b want 01", {e, gated});
    end
  endtask

  task automatic test_limits();
    limit = 8'd0;
    busy  = 1'b1;
    step(3);
    busy = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      step(1);
      total++;
      if ({e, gated} !== 2'b10) begin
        bad++;
        $display("FAIL limit0_cycle%0d: got E/GATED=%b want 10", i, {e, gated});
      end
    end
    limit = 8'd1;
    step(1);
    total++;
    if ({e, gated} !== 2'b01) begin
      bad++;
      $display("FAIL limit1_gate: got E/GATED=%b want 01", {e, gated});
    end
    limit = 8'd200;
    busy  = 1'b1;
    step(3);
    busy = 1'b0;
    step(50);
    total++;
    if (gated !== 1'b0) begin
      bad++;
      $display("FAIL limit200_count50: got GATED=%b want 0", gated);
    end
    limit = 8'd3;
    step(1);
    total++;
    if (gated !== 1'b1) begin
      bad++;
      $display("FAIL limit_lowered: got GATED=%b want 1", gated);
    end
  endtask

  task automatic test_overrides();
    se = 1'b1;
    #1;
    total++;
    if (te !== 1'b1) begin
      bad++;
      $display("FAIL se_te: got TE=%b want 1", te);
    end
    step(1);
    total++;
    if ({e, gated} !== 2'b01) begin
      bad++;
      $display("FAIL se_no_state: got E/GATED=%b want 01", {e, gated});
    end
    se = 1'b0;
    #1;
    total++;
    if (te !== 1'b0) begin
      bad++;
      $display("FAIL se_release_te: got TE=%b want 0", te);
    end
    force_on = 1'b1;
    #1;
    total++;
    if (te !== 1'b1) begin
      bad++;
      $display("FAIL force_te: got TE=%b want 1", te);
    end
    step(1);
    total++;
    if ({e, ready, gated} !== 3'b100) begin
      bad++;
      $display("FAIL force_wake: got E/READY/GATED=%b want 100", {e, ready, gated});
    end
    step(12);
    total++;
    if ({e, ready, gated} !== 3'b110) begin
      bad++;
      $display("FAIL force_hold: got E/READY/GATED=%b want 110", {e, ready, gated});
    end
    force_on = 1'b0;
    step(2);
    total++;
    if (gated !== 1'b0) begin
      bad++;
      $display("FAIL force_release_early: got GATED=%b want 0", gated);
    end
    step(1);
    total++;
    if ({e, gated} !== 2'b01) begin
      bad++;
      $display("FAIL force_release_gate: got E/GATED=%b want 01", {e, gated});
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({e, ready, gated} !== 3'b100) begin
      bad++;
      $display("FAIL rst_async: got E/READY/GATED=%b want 100", {e, ready, gated});
    end
    busy = 1'b1;
    #2;
    rst = 1'b0;
    step(1);
    total++;
    if (ready !== 1'b0) begin
      bad++;
      $display("FAIL rst_rel_edge1: got READY=%b want 0", ready);
    end
    step(1);
    total++;
    if (ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_rel_edge2: got READY=%b want 1", ready);
    end
  endtask

  initial begin
    rst      = 1'b1;
    busy     = 1'b1;
    req      = 1'b0;
    force_on = 1'b0;
    se       = 1'b0;
    limit    = 8'd4;
    test_reset();
    test_idle_timeout();
    test_wake();
    test_limits();
    test_overrides();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/icg_enable_ctrl.md
# icg_enable_ctrl

Idle-timeout enable controller for the negative-edge integrated clock gate (icgtn). Runs on the free-running clock that also drives the gate's CLKN. Watches downstream activity and wake requests, drives the gate's E and TE pins, and reports through a REQ/READY handshake whether the gated domain clock is running and stable.

## Interface
- `CNT_W`, default 8: idle counter and `IDLE_LIMIT` width.
- `WAKE_LAT`, default 2: cycles E is held high before READY asserts after ungating. Range 0..15.

Ports:
- `CLK` in 1: free-running clock. The same net drives the icgtn CLKN.
- `RST` in 1: asynchronous, active-high reset.
- `BUSY` in 1: gated-domain activity. High means the domain needs its clock.
- `REQ` in 1: wake request. Level-held until READY is seen high.
- `FORCE_ON` in 1: keeps the clock ungated; disables idle counting.
- `SE` in 1: scan enable.
- `IDLE_LIMIT` in CNT_W: consecutive idle cycles before gating. 0 disables gating.
- `E` out 1: functional enable to icgtn E. Registered.
- `TE` out 1: test enable to icgtn TE. Combinational: `SE | FORCE_ON`.
- `READY` out 1: domain clock running and stable. Registered.
- `GATED` out 1: domain clock stopped. Registered.

## Operation
An idle cycle is an edge where `!BUSY && !REQ && !FORCE_ON`.

States:
- **WAKE**
  - Outputs: E=1, READY=0, GATED=0.
  - `wcnt` decrements each edge; when `wcnt==1`, go to RUN.
- **RUN**
  - Outputs: E=1, READY=1, GATED=0.
  - Idle cycle with `IDLE_LIMIT!=0`:
    - If `IDLE_LIMIT==1`, go to GATED.
    - Otherwise go to IDLE with `icnt=1`.
- **IDLE**
  - Outputs: E=1, READY=1, GATED=0.
  - Idle cycle: `icnt` increments, saturating at all-ones.
  - When `icnt+1 >= IDLE_LIMIT`, go to GATED.
  - Non-idle cycle, or `IDLE_LIMIT==0`: go to RUN with `icnt=0`.
- **GATED**
  - Outputs: E=0, READY=0, GATED=1.
  - `REQ | BUSY | FORCE_ON`:
    - With `WAKE_LAT>0`, go to WAKE with `wcnt=WAKE_LAT`.
    - With `WAKE_LAT==0`, go straight to RUN.

Rules:
- Reset state is WAKE with `wcnt=WAKE_LAT`, or RUN when `WAKE_LAT==0`.
- Reset values: E=1, READY=0 (1 if `WAKE_LAT==0`), GATED=0, `icnt=0`.
- `IDLE_LIMIT` is sampled every edge and may change mid-count. The `>=` compare prevents a missed terminal count. A new limit at or below the current `icnt` gates on the next idle edge.
- E and READY never fall in the same edge that the wake condition is sampled true.
- READY is a registered decode of state. It never glitches.
- TE overrides E at the gate. Scan and FORCE_ON keep the clock running regardless of state.
- FSM state does not change because of SE.

## Timing
- E changes only after a CLK rising edge. It is stable for the full high phase before the CLKN falling edge, so it meets icgtn setup/hold with a half-cycle budget.
- Gate latency: the IDLE_LIMIT-th consecutive idle sample at edge k drives E=0 after edge k. The domain's last clock pulse is the one in progress.
- Wake latency: wake condition sampled at edge k in GATED gives E=1 after edge k and READY=1 after edge k+WAKE_LAT.
- Reset:
  - RST assertion forces E=1 immediately, asynchronously. Asserting RST mid-GATED ungates the clock within the same cycle.
  - After RST deasserts, READY=1 after the WAKE_LAT-th rising edge.
- BUSY and REQ are both high while in IDLE: return to RUN, no gating.
- BUSY drops the same edge FORCE_ON drops: that edge counts as non-idle.

## Structure
- Package `icg_ctrl_pkg` holds:
  - the state enum `icg_state_t` (WAKE, RUN, IDLE, GATED), 2-bit encoding;
  - the constant for the `WAKE_LAT` counter width (4).
- One sub-module, `icg_idle_counter`:
  - a saturating CNT_W up-counter;
  - inputs: clear, increment, limit;
  - output: `reached = (cnt+1 >= limit) && limit!=0`.
- The top holds the FSM, the wake counter and the output registers.

## Test plan
- **Reset:** assert RST, release, with `WAKE_LAT=2`, `BUSY=1` → E=1 throughout; READY=0 for 2 edges, then 1; GATED=0.
- **Idle timeout:** `IDLE_LIMIT=4`; drop BUSY at edge 10 → E=0 and GATED=1 after edge 13; BUSY pulse at edge 12 instead → no gating, counter restarts.
- **Wake handshake:** in GATED, raise REQ at edge 20 with `WAKE_LAT=2` → E=1 after 20, READY=1 after 22; REQ dropped after READY → gating again after IDLE_LIMIT idle edges.
- **Limits:** `IDLE_LIMIT=0` → never gates over 1000 idle cycles. `IDLE_LIMIT=1` → gates on the first idle edge. Lower the limit from 200 to 3 at `icnt=50` → gates next idle edge.
- **Overrides:** SE=1 or FORCE_ON=1 in any state → TE=1 same cycle; FORCE_ON in GATED → WAKE. RST mid-GATED → E=1 asynchronously.
- **Zero wake latency:** `WAKE_LAT=0` → REQ at edge k in GATED gives E=1 and READY=1 both after edge k.
